// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC rotation controller: FSM states,
// operand limits and the size of the arctangent table.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ROT  = 2'd2,
        FIN  = 2'd3
    } state_e;

    // Largest legal |angle1| in Q4.10 (just under pi/2)
    localparam int ANGLE_MAX = 1608;
    // Largest legal radius in Q4.10 (just under 4.0)
    localparam int R_MAX     = 4095;
    // Number of entries the arctangent table can supply
    localparam int ATAN_LEN  = 14;
    // Width of the iteration counter / table index (holds 0..ATAN_LEN)
    localparam int IDX_W     = $clog2(ATAN_LEN + 1);

    // True when both operands lie inside the range the datapath is sized for
    function automatic logic operands_legal(input int r, input int a);
        return (r >= 0) && (r <= R_MAX) && (a >= -ANGLE_MAX) && (a <= ANGLE_MAX);
    endfunction

endpackage

// File: rtl/cordic_rot_ctrl_if.sv
// Request/response bundle of the CORDIC rotation controller.
// The requester drives start and the operands; the controller returns
// busy, the done pulse and the rotated vector with its error flag.
interface cordic_rot_ctrl_if #(
    parameter int W = 14
);
    logic                start;
    logic signed [W-1:0] R_fixed;
    logic signed [W-1:0] angle1;
    logic                busy;
    logic                done;
    logic signed [W-1:0] X;
    logic signed [W-1:0] Y;
    logic                err;

    modport master (
        output start, R_fixed, angle1,
        input  busy, done, X, Y, err
    );

    modport slave (
        input  start, R_fixed, angle1,
        output busy, done, X, Y, err
    );
endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table: idx -> atan(2^-idx) in Q4.(10+GUARD).
// Entries are stored at 2^24 scale and rounded to nearest on the way out.
// Entries for idx >= 11 are kept one below their power-of-two value because
// the true angle lies just under it; this keeps the final rounding correct
// for every GUARD in 0..14.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int W     = 14,
    parameter int GUARD = 2
) (
    input  logic [IDX_W-1:0]      idx,
    output logic signed [W+GUARD:0] atan_o
);

    localparam int          ZW  = W + GUARD + 1;
    localparam int          SH  = 24 - (10 + GUARD);
    localparam logic [31:0] RND = 32'((1 << SH) >> 1);

    logic [31:0] t24;
    logic [31:0] rounded;

    // Select the high-precision angle and round it to the datapath scale
    always_comb begin
        t24 = '0;
        case (idx)
            4'd0:    t24 = 32'd13176795;
            4'd1:    t24 = 32'd7778716;
            4'd2:    t24 = 32'd4110060;
            4'd3:    t24 = 32'd2086331;
            4'd4:    t24 = 32'd1047214;
            4'd5:    t24 = 32'd524117;
            4'd6:    t24 = 32'd262123;
            4'd7:    t24 = 32'd131069;
            4'd8:    t24 = 32'd65536;
            4'd9:    t24 = 32'd32768;
            4'd10:   t24 = 32'd16384;
            4'd11:   t24 = 32'd8191;
            4'd12:   t24 = 32'd4095;
            4'd13:   t24 = 32'd2047;
            default: t24 = '0;
        endcase
        rounded = (t24 + RND) >> SH;
        atan_o  = ZW'(rounded);
    end

endmodule

// File: rtl/cordic_rot_ctrl.sv
// Iterative CORDIC rotator: rotates (R_fixed, 0) by angle1 using ITER
// shift-add micro-rotations, one per clock. The CORDIC gain is left in the
// result. Out-of-range operands finish immediately with err set.
module cordic_rot_ctrl
    import cordic_pkg::*;
#(
    parameter int W     = 14,
    parameter int ITER  = 12,
    parameter int GUARD = 2
) (
    input  logic             clk,
    input  logic             rst,
    cordic_rot_ctrl_if.slave bus
);

    // One extra integer bit over the operands absorbs the ~1.65 gain
    localparam int               XW     = W + GUARD + 1;
    localparam int               HALF   = (1 << GUARD) >> 1;
    localparam logic [IDX_W-1:0] I_LAST = IDX_W'(ITER - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      i_q, i_d;
    logic signed [XW-1:0]  x_q, x_d;
    logic signed [XW-1:0]  y_q, y_d;
    logic signed [XW-1:0]  z_q, z_d;
    logic signed [W-1:0]   r_q, r_d;
    logic signed [W-1:0]   a_q, a_d;
    logic signed [W-1:0]   xo_q, xo_d;
    logic signed [W-1:0]   yo_q, yo_d;
    logic                  err_q, err_d;

    logic signed [XW-1:0]  atan_val;
    logic signed [XW-1:0]  x_sh, y_sh;
    logic signed [XW-1:0]  x_nxt, y_nxt, z_nxt;
    logic                  legal;

    // Drop the guard bits, rounding half-up
    function automatic logic signed [W-1:0] round_out(input logic signed [XW-1:0] v);
        logic signed [XW-1:0] s;
        s = (v + XW'(HALF)) >>> GUARD;
        return s[W-1:0];
    endfunction

    cordic_atan_rom #(
        .W     (W),
        .GUARD (GUARD)
    ) u_atan_rom (
        .idx    (i_q),
        .atan_o (atan_val)
    );

    // One micro-rotation: direction follows the sign of the residual angle
    always_comb begin
        x_sh = x_q >>> i_q;
        y_sh = y_q >>> i_q;
        if (!z_q[XW-1]) begin
            x_nxt = x_q - y_sh;
            y_nxt = y_q + x_sh;
            z_nxt = z_q - atan_val;
        end else begin
            x_nxt = x_q + y_sh;
            y_nxt = y_q - x_sh;
            z_nxt = z_q + atan_val;
        end
    end

    // Next-state, counter and datapath update for the controller FSM
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        r_d     = r_q;
        a_d     = a_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        err_d   = err_q;
        legal   = operands_legal(int'(bus.R_fixed), int'(bus.angle1));

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (legal) begin
                        r_d     = bus.R_fixed;
                        a_d     = bus.angle1;
                        state_d = LOAD;
                    end else begin
                        xo_d    = '0;
                        yo_d    = '0;
                        err_d   = 1'b1;
                        state_d = FIN;
                    end
                end
            end
            LOAD: begin
                x_d     = XW'(r_q) <<< GUARD;
                y_d     = '0;
                z_d     = XW'(a_q) <<< GUARD;
                i_d     = '0;
                state_d = ROT;
            end
            ROT: begin
                x_d = x_nxt;
                y_d = y_nxt;
                z_d = z_nxt;
                i_d = i_q + 1'b1;
                if (i_q == I_LAST) begin
                    // Results are published on the edge into FIN so they are valid with done
                    xo_d    = round_out(x_nxt);
                    yo_d    = round_out(y_nxt);
                    err_d   = 1'b0;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and result registers; reset clears everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            r_q     <= '0;
            a_q     <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            r_q     <= r_d;
            a_q     <= a_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == FIN);
    assign bus.X    = xo_q;
    assign bus.Y    = yo_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_cordic_rot_ctrl.sv
// Directed plus randomized bench for cordic_rot_ctrl with a behavioural
// CORDIC reference model.
module tb_cordic_rot_ctrl;

    localparam int W     = 14;
    localparam int ITER  = 12;
    localparam int GUARD = 2;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    cordic_rot_ctrl_if #(.W(W)) bus ();

    cordic_rot_ctrl #(
        .W     (W),
        .ITER  (ITER),
        .GUARD (GUARD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp, input int tol);
        checks++;
        assert (((obs - exp) <= tol) && ((exp - obs) <= tol)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    // Reference rotation: real-valued angle table, integer shift-add loop
    function automatic void model(input int r, input int a, output int xe, output int ye, output int ee);
        longint x, y, z, xn;
        longint at;
        real    ang;
        if (r < 0 || r > 4095 || a < -1608 || a > 1608) begin
            xe = 0; ye = 0; ee = 1;
            return;
        end
        x = longint'(r) * (1 << GUARD);
        y = 0;
        z = longint'(a) * (1 << GUARD);
        for (int i = 0; i < ITER; i++) begin
            ang = $atan(1.0 / real'(1 << i)) * real'(1 << (10 + GUARD));
            at  = longint'($rtoi($floor(ang + 0.5)));
            if (z >= 0) begin
                xn = x - (y >>> i);
                y  = y + (x >>> i);
                z  = z - at;
            end else begin
                xn = x + (y >>> i);
                y  = y - (x >>> i);
                z  = z + at;
            end
            x = xn;
        end
        xe = int'((x + (1 << (GUARD - 1))) >>> GUARD);
        ye = int'((y + (1 << (GUARD - 1))) >>> GUARD);
        ee = 0;
    endfunction

    // Issue one start and follow it to done, checking everything against the model
    task automatic do_op(input string tag, input int r, input int a, input bit spam,
                         output int xo, output int yo);
        int xe, ye, ee;
        int x0, y0, e0;
        int lat, bcnt;
        bit stable;
        model(r, a, xe, ye, ee);
        x0 = int'(bus.X);
        y0 = int'(bus.Y);
        e0 = int'(bus.err);
        bus.start   = 1'b1;
        bus.R_fixed = W'(r);
        bus.angle1  = W'(a);
        lat    = 0;
        bcnt   = 0;
        stable = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.busy) bcnt++;
            if (bus.done) begin
                lat = n;
                break;
            end
            if (int'(bus.X) != x0 || int'(bus.Y) != y0 || int'(bus.err) != e0) stable = 1'b0;
            bus.start = spam;
            if (spam) begin
                bus.R_fixed = W'($urandom_range(0, 8191));
                bus.angle1  = W'($urandom_range(0, 16383));
            end
        end
        xo = int'(bus.X);
        yo = int'(bus.Y);
        check({tag, " latency"}, lat, (ee != 0) ? 1 : ITER + 2);
        check({tag, " busy cycles"}, bcnt, (ee != 0) ? 1 : ITER + 2);
        check({tag, " outputs held while busy"}, int'(stable), 1);
        check({tag, " err"}, int'(bus.err), ee);
        check({tag, " X"}, xo, xe);
        check({tag, " Y"}, yo, ye);
        // First IDLE cycle: a start held through FIN must not have been taken
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " idle busy"}, int'(bus.busy), 0);
        check({tag, " idle done"}, int'(bus.done), 0);
        @(negedge clk);
        check({tag, " no extra run"}, int'(bus.busy) + int'(bus.done), 0);
    endtask

    initial begin
        int xo, yo;
        int r, a, sel;
        int dcnt;

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.R_fixed = '0;
        bus.angle1  = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        check("reset err", int'(bus.err), 0);
        check("reset X", int'(bus.X), 0);
        check("reset Y", int'(bus.Y), 0);
        rst = 1'b0;
        @(negedge clk);

        // Rotation of unit radius by 0
        do_op("r1024_a0", 1024, 0, 1'b0, xo, yo);
        check_near("r1024_a0 X gain", xo, 1686, 4);
        check_near("r1024_a0 Y gain", yo, 0, 4);

        // Quarter turns at the angle limits
        do_op("r1024_a+max", 1024, 1608, 1'b0, xo, yo);
        check_near("a+max X", xo, 0, 4);
        check_near("a+max Y", yo, 1686, 4);
        do_op("r1024_a-max", 1024, -1608, 1'b0, xo, yo);
        check_near("a-max X", xo, 0, 4);
        check_near("a-max Y", yo, -1686, 4);

        // Eighth turn
        do_op("r1024_a804", 1024, 804, 1'b0, xo, yo);
        check_near("a804 X", xo, 1192, 4);
        check_near("a804 Y", yo, 1192, 4);

        // Illegal operands, each followed by a normal run
        do_op("a1700 illegal", 1024, 1700, 1'b0, xo, yo);
        do_op("after illegal", 1024, 0, 1'b0, xo, yo);
        check_near("after illegal X", xo, 1686, 4);
        do_op("r4096 illegal", 4096, 0, 1'b0, xo, yo);
        do_op("a+1609 illegal", 1000, 1609, 1'b0, xo, yo);
        do_op("a-1609 illegal", 1000, -1609, 1'b0, xo, yo);
        do_op("r-1 illegal", -1, 100, 1'b0, xo, yo);

        // Zero radius and the largest radius
        do_op("r0", 0, 1000, 1'b0, xo, yo);
        do_op("r4095 a-1000", 4095, -1000, 1'b0, xo, yo);

        // Start held high for the whole run, operands scrambled mid-run
        do_op("spam", 3000, -500, 1'b1, xo, yo);
        do_op("spam2", 2222, 1500, 1'b1, xo, yo);

        // Randomized operands, mostly legal
        for (int k = 0; k < 24; k++) begin
            sel = int'($urandom_range(0, 7));
            r   = int'($urandom_range(0, 4095));
            a   = int'($urandom_range(0, 3216)) - 1608;
            if (sel == 0) a = int'($urandom_range(1609, 8191));
            if (sel == 1) r = int'($urandom_range(4096, 8191));
            if (sel == 2) a = -int'($urandom_range(1609, 8192));
            do_op($sformatf("rand%0d r%0d a%0d", k, r, a), r, a, ($urandom_range(0, 3) == 0), xo, yo);
        end

        // Reset in the middle of a rotation
        bus.start   = 1'b1;
        bus.R_fixed = W'(2048);
        bus.angle1  = W'(300);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre-abort busy", int'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check("abort busy", int'(bus.busy), 0);
        check("abort done", int'(bus.done), 0);
        check("abort X", int'(bus.X), 0);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        for (int n = 0; n < ITER + 6; n++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dcnt++;
        end
        check("no done after abort", dcnt, 0);
        do_op("after abort", 1024, 0, 1'b0, xo, yo);
        check_near("after abort X", xo, 1686, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
